// File: rtl/vred_bitwise_seq_unit.sv
// ---------------------------------------------------------------------------
// vred_bitwise_seq_unit
// Multi-beat vector reduction unit (vredand / vredor / vredxor, optional
// min/max). Each accepted beat carries LANES elements; active lanes are folded
// by a balanced tree and the beat result is folded into an accumulator seeded
// from the scalar operand. One scalar result is emitted per vector.
//
// Build option:
//   VRED_MINMAX_EN  defined   -> opSel 1xx performs MINU/MAXU/MIN/MAX
//                   undefined -> no comparators; opSel 1xx behaves as pass
//
// Handshake rules (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Once out_valid is high, out_data stays
// stable until the transfer completes. in_ready is registered and is low
// during reset, while a result waits in DONE, and in the first cycle after
// reset release.
// ---------------------------------------------------------------------------
module vred_bitwise_seq_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int OPSEL_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic [LANES-1:0]            in_mask,
    input  logic [DATA_WIDTH-1:0]       in_scalar,
    input  logic [OPSEL_WIDTH-1:0]      in_opSel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [1:0]                  dbg_state
);

    // FSM encoding
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ACCUM = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    // Opcode encoding (bits [2:0] of in_opSel)
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
`ifdef VRED_MINMAX_EN
    localparam logic [2:0] OP_MINU = 3'b100;
    localparam logic [2:0] OP_MAXU = 3'b101;
    localparam logic [2:0] OP_MIN  = 3'b110;
    localparam logic [2:0] OP_MAX  = 3'b111;
`endif

    localparam int LVLS = $clog2(LANES);

    // Map the raw opcode to the operation actually performed. Without the
    // min/max group the whole 1xx space collapses onto pass.
    function automatic logic [2:0] norm_op(input logic [2:0] sel);
`ifdef VRED_MINMAX_EN
        return sel;
`else
        return sel[2] ? OP_PASS : sel;
`endif
    endfunction

    // Identity element substituted for masked lanes.
    function automatic logic [DATA_WIDTH-1:0] op_ident(input logic [2:0] op);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_AND:  r = '1;
`ifdef VRED_MINMAX_EN
            OP_MINU: r = '1;
            OP_MIN:  r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            OP_MAX:  r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Two-operand combine; pass keeps the left operand so that beats never
    // disturb a pass accumulator.
    function automatic logic [DATA_WIDTH-1:0] op2(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b,
                                                  input logic [2:0]            op);
        logic [DATA_WIDTH-1:0] r;
        r = a;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
`ifdef VRED_MINMAX_EN
            OP_MINU: r = (a < b) ? a : b;
            OP_MAXU: r = (a > b) ? a : b;
            OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
`endif
            default: r = a;
        endcase
        return r;
    endfunction

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  ready_q;

    logic [2:0]            first_op;
    logic [2:0]            beat_op;
    logic                  beat_fire;
    logic [DATA_WIDTH-1:0] beat_red;

    assign first_op  = norm_op(in_opSel[2:0]);
    // A beat carrying in_first starts a new vector, so it is reduced with the
    // new opcode rather than the latched one.
    assign beat_op   = in_first ? first_op : op_q;
    assign beat_fire = in_valid & ready_q;

    // Balanced reduction tree: level 0 holds masked lanes, each further level
    // halves the node count until a single root remains.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [DATA_WIDTH-1:0] node [LANES>>l];
        for (genvar n = 0; n < (LANES >> l); n++) begin : g_node
            if (l == 0) begin : g_leaf
                assign node[n] = in_mask[n] ? in_data[n*DATA_WIDTH +: DATA_WIDTH]
                                            : op_ident(beat_op);
            end else begin : g_comb
                assign node[n] = op2(g_lvl[l-1].node[2*n], g_lvl[l-1].node[2*n+1], beat_op);
            end
        end
    end

    assign beat_red = g_lvl[LVLS].node[0];

    // Next-state logic for the FSM, accumulator and result register
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (beat_fire && in_first) begin
                    acc_d   = op2(in_scalar, beat_red, first_op);
                    op_d    = first_op;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_fire) begin
                    if (in_first) begin
                        // Abandon the partial vector and reseed.
                        acc_d = op2(in_scalar, beat_red, first_op);
                        op_d  = first_op;
                    end else begin
                        acc_d = op2(acc_q, beat_red, op_q);
                    end
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The visible result only changes on entry to DONE.
        if ((state_q != DONE) && (state_d == DONE)) begin
            out_data_d = acc_d;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            op_q       <= OP_PASS;
            out_data_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
            ready_q    <= (state_d != DONE);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vred_bitwise_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_vred_bitwise_seq_unit
// Directed bench: a table of single-beat vectors plus hand-written sequences
// for multi-beat, back-pressure, mid-vector restart and async reset cases.
// Expected values are hand-computed; min/max expectations follow
// VRED_MINMAX_EN.
// ---------------------------------------------------------------------------
module tb_vred_bitwise_seq_unit;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int OW = 3;

`ifdef VRED_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    localparam logic [2:0] P_PASS = 3'b000;
    localparam logic [2:0] P_AND  = 3'b001;
    localparam logic [2:0] P_OR   = 3'b010;
    localparam logic [2:0] P_XOR  = 3'b011;
    localparam logic [2:0] P_MINU = 3'b100;
    localparam logic [2:0] P_MAXU = 3'b101;
    localparam logic [2:0] P_MIN  = 3'b110;
    localparam logic [2:0] P_MAX  = 3'b111;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic              in_last;
    logic [L*DW-1:0]   in_data;
    logic [L-1:0]      in_mask;
    logic [DW-1:0]     in_scalar;
    logic [OW-1:0]     in_opSel;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        dbg_state;

    vred_bitwise_seq_unit #(
        .DATA_WIDTH (DW),
        .LANES      (L),
        .OPSEL_WIDTH(OW)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_mask  (in_mask),
        .in_scalar(in_scalar),
        .in_opSel (in_opSel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total;
    int bad;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [2:0]      op;
        logic [DW-1:0]   scalar;
        logic [L*DW-1:0] data;
        logic [L-1:0]    mask;
        logic [DW-1:0]   exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic first, input logic last, input logic [2:0] op,
                             input logic [DW-1:0] sc, input logic [L*DW-1:0] d,
                             input logic [L-1:0] m);
        int n;
        in_first  = first;
        in_last   = last;
        in_opSel  = op;
        in_scalar = sc;
        in_data   = d;
        in_mask   = m;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("beat_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the in_last beat is accepted: the result must be
    // present in this very cycle, then it is drained.
    task automatic expect_result(input string name);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        @(negedge clk);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"}, out_data, e);
        check({name, "_inrdy"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        total = 0;
        bad   = 0;

        // Single-beat vectors (in_first & in_last). Lane 0 is the low word.
        vecs[0] = '{P_AND, 32'hFFFF_FFFF,
                    {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0FFF, 32'hF0F0_FFFF},
                    4'b1111, 32'hF0F0_0FFF};
        vecs[1] = '{P_OR, 32'h0, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1010, 32'h0000_000A};
        vecs[2] = '{P_XOR, 32'hFF, {32'h00, 32'h03, 32'hF0, 32'h0F}, 4'b1111, 32'h0000_0003};
        vecs[3] = '{P_PASS, 32'hDEAD_BEEF, {32'h1, 32'h2, 32'h3, 32'h4}, 4'b1111, 32'hDEAD_BEEF};
        vecs[4] = '{P_AND, 32'h1234_5678, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 32'h1234_5678};
        vecs[5] = '{P_MAXU, 32'h5, {32'hFFFF_FFFF, 32'h3, 32'h9, 32'h1}, 4'b0111,
                    MM ? 32'h9 : 32'h5};
        vecs[6] = '{P_MIN, 32'h0, {32'h2, 32'h7, 32'hFFFF_FFFD, 32'h5}, 4'b1111,
                    MM ? 32'hFFFF_FFFD : 32'h0};
        vecs[7] = '{P_MINU, 32'h0, {32'h2, 32'h7, 32'hFFFF_FFFD, 32'h5}, 4'b1111, 32'h0};
        vecs[8] = '{P_MAX, 32'hFFFF_FFF0, {32'h2, 32'h7, 32'hFFFF_FFFD, 32'h5}, 4'b1101,
                    MM ? 32'h7 : 32'hFFFF_FFF0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_scalar = '0;
        in_opSel  = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table of single-beat vectors
        for (int i = 0; i < 9; i++) begin
            send_beat(1'b1, 1'b1, vecs[i].op, vecs[i].scalar, vecs[i].data, vecs[i].mask);
            exp_q.push_back(vecs[i].exp);
            expect_result($sformatf("vec%0d", i));
        end

        // Three-beat OR with a partially masked middle beat
        send_beat(1'b1, 1'b0, P_OR, 32'h0, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1111);
        check("or3_mid_valid", {31'd0, out_valid}, 32'd0);
        send_beat(1'b0, 1'b0, P_OR, 32'h0, {32'h80, 32'h40, 32'h20, 32'h10}, 4'b0101);
        check("or3_state", {30'd0, dbg_state}, 32'd1);
        send_beat(1'b0, 1'b1, P_OR, 32'h0, {32'h800, 32'h400, 32'h200, 32'h100}, 4'b1111);
        exp_q.push_back(32'h0000_0F5F);
        expect_result("or3");

        // Pass over two beats: beats ignored
        send_beat(1'b1, 1'b0, P_PASS, 32'hCAFE_F00D, {32'h1, 32'h2, 32'h3, 32'h4}, 4'b1111);
        send_beat(1'b0, 1'b1, P_PASS, 32'h0, {32'h5, 32'h6, 32'h7, 32'h8}, 4'b1111);
        exp_q.push_back(32'hCAFE_F00D);
        expect_result("pass2");

        // XOR fully masked, result held under back-pressure while a new beat waits
        send_beat(1'b1, 1'b1, P_XOR, 32'h1234_5678, {32'hAA, 32'hBB, 32'hCC, 32'hDD}, 4'b0000);
        @(negedge clk);
        check("hold_valid0", {31'd0, out_valid}, 32'd1);
        check("hold_data0", out_data, 32'h1234_5678);
        in_first  = 1'b1;
        in_last   = 1'b1;
        in_opSel  = P_OR;
        in_scalar = 32'hFFFF_FFFF;
        in_mask   = 4'b1111;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold_valid%0d", k + 1), {31'd0, out_valid}, 32'd1);
            check($sformatf("hold_data%0d", k + 1), out_data, 32'h1234_5678);
            check($sformatf("hold_inrdy%0d", k + 1), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_drain", {31'd0, out_valid}, 32'd0);
        tick();
        check("hold_no_phantom", {31'd0, out_valid}, 32'd0);
        check("hold_idle", {30'd0, dbg_state}, 32'd0);
        check("hold_data_kept", out_data, 32'h1234_5678);

        // Beat without in_first in IDLE is dropped
        send_beat(1'b0, 1'b1, P_OR, 32'hFFFF_FFFF, {32'h1, 32'h1, 32'h1, 32'h1}, 4'b1111);
        tick();
        check("drop_valid", {31'd0, out_valid}, 32'd0);
        check("drop_state", {30'd0, dbg_state}, 32'd0);

        // in_first mid-vector abandons the partial OR
        send_beat(1'b1, 1'b0, P_OR, 32'h0000_0F00, {32'h1000, 32'h2000, 32'h4000, 32'h8000}, 4'b1111);
        send_beat(1'b0, 1'b0, P_OR, 32'h0, {32'h1, 32'h2, 32'h4, 32'h8}, 4'b1111);
        check("restart_state", {30'd0, dbg_state}, 32'd1);
        send_beat(1'b1, 1'b1, P_OR, 32'h0000_0001, {32'h0, 32'h0, 32'h0, 32'h10}, 4'b1111);
        exp_q.push_back(32'h0000_0011);
        expect_result("restart");
        tick();
        check("restart_single", {31'd0, out_valid}, 32'd0);

        // Async reset mid-ACCUM, between clock edges
        send_beat(1'b1, 1'b0, P_AND, 32'hFFFF_FFFF, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b1111);
        check("accum_inrdy", {31'd0, in_ready}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_inrdy", {31'd0, in_ready}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Async reset while a result waits in DONE
        send_beat(1'b1, 1'b1, P_OR, 32'h0, {32'h0, 32'h0, 32'h0, 32'h77}, 4'b1111);
        check("arst_done_pre", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_done_valid", {31'd0, out_valid}, 32'd0);
        check("arst_done_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Next vector after reset is clean
        send_beat(1'b1, 1'b1, P_OR, 32'h0000_0100, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1111);
        exp_q.push_back(32'h0000_010F);
        expect_result("post_arst");

        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
